// File: rtl/sram_arbiter.sv
// sram_arbiter: fixed-priority (data over fetch) arbiter sharing one async SRAM.
// States: IDLE arbitrate | RD read strobe | WR_SETUP/WR_PULSE/WR_HOLD write | DONE ack | TURN bus rest (SRAM_TURNAROUND_EN)
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_conflict,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_data,
  output logic        sram_en_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE, S_TURN
  } state_t;

  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_dm_q, owner_dm_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;
  logic        drive_bus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (dm_req) begin
          owner_dm_d = 1'b1;
          we_d       = dm_we;
          addr_d     = dm_addr;
          wdata_d    = dm_wdata;
          cnt_d      = WAIT_LD;
          state_d    = dm_we ? S_WR_SETUP : S_RD;
        end else if (if_req) begin
          owner_dm_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = if_addr;
          cnt_d      = WAIT_LD;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == 3'd0) begin
          if (owner_dm_q) dm_rdata_d = sram_data;
          else            if_rdata_d = sram_data;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_q == 3'd0) state_d = S_WR_HOLD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE: begin
`ifdef SRAM_TURNAROUND_EN
        state_d = we_q ? S_TURN : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so reset releases the SRAM at once.
  assign drive_bus    = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) || (state_q == S_WR_HOLD);
  assign sram_data    = drive_bus ? wdata_q : 16'hzzzz;
  assign sram_en_n    = !((state_q == S_RD) || drive_bus);
  assign sram_oe_n    = !((state_q == S_RD) && !we_q);
  assign sram_we_n    = (state_q != S_WR_PULSE);
  assign sram_addr    = {2'b00, addr_q};
  assign if_ack       = (state_q == S_DONE) && !owner_dm_q;
  assign dm_ack       = (state_q == S_DONE) && owner_dm_q;
  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;
  assign mem_conflict = if_req && (((state_q != S_IDLE) && owner_dm_q) ||
                                   ((state_q == S_IDLE) && dm_req));

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM on a pulled-up bus.
module tb_sram_arbiter;
  localparam int W = 1;
`ifdef SRAM_TURNAROUND_EN
  localparam int TURN = 1;
`else
  localparam int TURN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic [15:0] if_rdata, dm_rdata;
  logic        if_ack, dm_ack, mem_conflict;
  logic [17:0] sram_addr;
  logic        sram_en_n, sram_oe_n, sram_we_n;
  tri1  [15:0] sram_data;

  typedef struct packed {
    logic        dm;
    logic [15:0] d;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_dm_rd;
  logic [15:0] addrs [5] = '{16'h0010, 16'h0020, 16'h0030, 16'h8050, 16'h0077};
  int          n_cmp = 0;
  int          n_bad = 0;
  int          oe_cnt = 0, we_cnt = 0, drv_cnt = 0, dm_ack_cnt = 0;
  logic [17:0] last_addr = '0;
  logic        prev_if_ack = 1'b0, prev_dm_ack = 1'b0;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_conflict(mem_conflict),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_en_n(sram_en_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  assign sram_data = (!sram_en_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge clk)
    if (!sram_en_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_we_n) we_cnt++;
    if (sram_oe_n && sram_data != 16'hFFFF) drv_cnt++;
    if (!sram_en_n) last_addr = sram_addr;
    if (dm_ack) dm_ack_cnt++;
    if (if_ack || dm_ack) begin
      check_eq("sb_has_entry", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check_eq("ack_port", {if_ack, dm_ack}, {!e.dm, e.dm});
        if (e.dm) check_eq("dm_rdata", dm_rdata, e.d);
        else      check_eq("if_rdata", if_rdata, e.d);
      end
      check_eq("ack_width", prev_if_ack | prev_dm_ack, 0);
    end
    prev_if_ack = if_ack;
    prev_dm_ack = dm_ack;
  end

  task automatic push_data(input logic we, input logic [15:0] a, input logic [15:0] wd);
    if (we) ref_mem[a[7:0]] = wd;
    else    exp_dm_rd = ref_mem[a[7:0]];
    sbq.push_back('{1'b1, exp_dm_rd});
  endtask

  task automatic fetch(input logic [15:0] a, input bit scr, input bit psh, output int n);
    if (psh) sbq.push_back('{1'b0, ref_mem[a[7:0]]});
    @(negedge clk);
    if_addr = a;
    if_req  = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1 if (scr && n == 1) if_addr = 16'($urandom);
      @(negedge clk);
    end while (!if_ack && n < 40);
    check_eq("if_ack_seen", if_ack, 1);
    check_eq("if_sram_addr", last_addr, {2'b00, a});
    @(posedge clk);
    #1 if_req = 1'b0;
  endtask

  task automatic data(input logic we, input logic [15:0] a, input logic [15:0] wd,
                      input bit scr, input bit psh, output int n);
    if (psh) push_data(we, a, wd);
    @(negedge clk);
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    dm_req   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1 if (scr && n == 1) begin
        dm_addr  = 16'($urandom);
        dm_wdata = 16'($urandom);
        dm_we    = ~we;
      end
      @(negedge clk);
    end while (!dm_ack && n < 40);
    check_eq("dm_ack_seen", dm_ack, 1);
    check_eq("dm_sram_addr", last_addr, {2'b00, a});
    @(posedge clk);
    #1 dm_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n_dm, n_if, c_bad, k, base;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 16'h0101) ^ 16'h00A5;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h00A5;
    end
    mem[8'h10] = 16'h1234;  ref_mem[8'h10] = 16'h1234;
    mem[8'h30] = 16'h5555;  ref_mem[8'h30] = 16'h5555;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    exp_dm_rd = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_en_n", sram_en_n, 1);
    check_eq("rst_oe_n", sram_oe_n, 1);
    check_eq("rst_we_n", sram_we_n, 1);
    check_eq("rst_bus_z", sram_data, 16'hFFFF);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_acks", {if_ack, dm_ack}, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_dm_rdata", dm_rdata, 0);
    check_eq("rst_conflict_idle", mem_conflict, 0);
    if_req = 1'b1; dm_req = 1'b1;
    #1 check_eq("rst_conflict_both", mem_conflict, 1);
    dm_req = 1'b0;
    #1 check_eq("rst_conflict_if", mem_conflict, 0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // single fetch
    oe_cnt = 0;
    fetch(16'h0010, 1, 1, n);
    check_eq("fetch_latency", n, W + 2);
    check_eq("fetch_oe_cycles", oe_cnt, W + 1);
    check_eq("fetch_rdata", if_rdata, 16'h1234);

    // single write
    we_cnt = 0; drv_cnt = 0;
    data(1'b1, 16'h8000, 16'hBEEF, 1, 1, n);
    check_eq("write_latency", n, W + 4);
    check_eq("write_we_cycles", we_cnt, W + 1);
    check_eq("write_drive_cycles", drv_cnt, W + 3);
    check_eq("write_sram_content", mem[8'h00], 16'hBEEF);
    check_eq("write_keeps_dm_rdata", dm_rdata, 0);

    // write then read back-to-back
    data(1'b1, 16'h0020, 16'hCAFE, 0, 1, n);
    data(1'b0, 16'h0020, 16'h0000, 0, 1, n);
    check_eq("rd_after_wr_latency", n, W + 2 + TURN);
    check_eq("rd_after_wr_data", dm_rdata, 16'hCAFE);

    // simultaneous requests: data first, fetch stalled
    push_data(1'b0, 16'h0030, 16'h0000);
    sbq.push_back('{1'b0, ref_mem[8'h10]});
    c_bad = 0;
    fork
      data(1'b0, 16'h0030, 16'h0000, 0, 0, n_dm);
      fetch(16'h0010, 0, 0, n_if);
      begin
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          #1 if (mem_conflict !== 1'b1) c_bad++;
          if (dm_ack) break;
        end
      end
    join
    check_eq("conflict_held", c_bad, 0);
    check_eq("conflict_dm_latency", n_dm, W + 2);
    check_eq("conflict_if_latency", n_if, 2 * W + 5);
    check_eq("conflict_dm_data", dm_rdata, 16'h5555);

    // reset in the middle of a write pulse
    push_data(1'b1, 16'h0040, 16'h1357);
    base = dm_ack_cnt;
    @(negedge clk);
    dm_we = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1357; dm_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sram_we_n && k < 20);
    check_eq("pulse_reached", sram_we_n, 0);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_we_n", sram_we_n, 1);
    check_eq("abort_en_n", sram_en_n, 1);
    check_eq("abort_bus_z", sram_data, 16'hFFFF);
    check_eq("abort_addr", sram_addr, 0);
    check_eq("abort_dm_ack", dm_ack, 0);
    check_eq("abort_dm_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    void'(sbq.pop_back());
    exp_dm_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_eq("abort_no_ack", dm_ack_cnt - base, 0);
    fetch(16'h0010, 1, 1, n);
    check_eq("post_rst_latency", n, W + 2);

    // mixed traffic
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a;
      int op;
      a  = addrs[$urandom_range(0, 4)];
      op = $urandom_range(0, 2);
      if (op == 0)      fetch(a, 0, 1, n);
      else if (op == 1) data(1'b0, a, 16'h0000, 0, 1, n);
      else              data(1'b1, a, 16'($urandom_range(0, 16'hFFFE)), 0, 1, n);
    end
    repeat (4) @(posedge clk);
    check_eq("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra SRAM access cycles; legal range 0..7.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req  in  1  instruction-fetch request; held high until if_ack sampled.
REQ-005 SHALL have port if_addr  in  16  fetch word address.
REQ-006 SHALL have port if_rdata  out  16  fetched instruction.
REQ-007 SHALL have port if_ack  out  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port dm_req  in  1  data-access request; held high until dm_ack sampled.
REQ-009 SHALL have port dm_we  in  1  1 = write, 0 = read.
REQ-010 SHALL have port dm_addr  in  16  data word address.
REQ-011 SHALL have port dm_wdata  in  16  write data.
REQ-012 SHALL have port dm_rdata  out  16  read data.
REQ-013 SHALL have port dm_ack  out  1  one-cycle data completion pulse.
REQ-014 SHALL have port mem_conflict  out  1  stall request to fetch stage.
REQ-015 SHALL have port sram_addr  out  18  SRAM address, {2'b00, granted addr}.
REQ-016 SHALL have port sram_data  inout  16  SRAM data bus.
REQ-017 SHALL have ports sram_en_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM enables.

Function
REQ-018 SHALL implement states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE (plus TURN, see REQ-033).
REQ-019 SHALL evaluate requests only in IDLE; data port wins when both requested (fixed priority).
REQ-020 SHALL latch owner, address, dm_we and dm_wdata at the grant edge; later input changes are ignored until DONE.
REQ-021 SHALL, read grant: IDLE->RD; RD lasts WAIT_CYCLES+1 cycles with en_n=0, oe_n=0, we_n=1, sram_data high-Z.
REQ-022 SHALL capture sram_data into the owner's rdata register at the last RD edge, then enter DONE.
REQ-023 SHALL, write grant (data port only): WR_SETUP 1 cycle (en_n=0, we_n=1, data driven), WR_PULSE WAIT_CYCLES+1 cycles (we_n=0), WR_HOLD 1 cycle (we_n=1, data still driven), then DONE.
REQ-024 SHALL drive sram_data only in WR_SETUP, WR_PULSE and WR_HOLD; high-Z otherwise; oe_n=1 during writes.
REQ-025 SHALL assert the owner's ack for exactly the DONE cycle, then return to IDLE; en_n=1 in DONE.
REQ-026 SHALL give latency grant edge -> ack of WAIT_CYCLES+2 cycles (read) and WAIT_CYCLES+4 cycles (write).
REQ-027 SHALL hold if_rdata/dm_rdata stable between that port's acks; a write never alters dm_rdata.
REQ-028 SHALL drive mem_conflict combinationally = if_req AND (owner is data port, or state IDLE and dm_req).
REQ-029 SHALL assume requesters drop req at the edge sampling ack; arbiter never grants in DONE, so no duplicate access.

Reset
REQ-030 SHALL, on rst low, immediately force IDLE, en_n/oe_n/we_n=1, sram_data high-Z, sram_addr=0, acks=0, rdata=0, mem_conflict follows REQ-028.
REQ-031 SHALL abort any in-flight access on reset without ack; no partial write pulse continues.
REQ-032 SHALL resume arbitration at the first rising edge after rst returns high.

Configuration
REQ-033 SHALL, with macro SRAM_TURNAROUND_EN defined, insert TURN (1 cycle, en_n=1, bus high-Z) between DONE and IDLE after writes only; without it DONE->IDLE directly.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=1, if_req addr 0x0010, SRAM returns 0x1234 -> if_ack 3 cycles after grant, if_rdata=0x1234, oe_n low 2 cycles.
REQ-035 SHALL cover: dm write addr 0x8000 data 0xBEEF -> we_n low exactly 2 cycles, data driven 4 cycles, dm_ack 5 cycles after grant.
REQ-036 SHALL cover: if_req and dm_req read in same IDLE cycle -> data served first, mem_conflict=1 until dm_ack, fetch then granted.
REQ-037 SHALL cover: rst low mid-WR_PULSE -> we_n=1 and bus high-Z same cycle, no dm_ack, IDLE after release.
REQ-038 SHALL cover: write then read back-to-back with SRAM_TURNAROUND_EN -> one extra high-Z cycle before read grant; without it, none.
